// File: rtl/piso_pkg.sv
// Shared widths and types for the parallel-in serial-out shift register.
package piso_pkg;

  localparam int NIB_W   = 4;
  localparam int CNT_W   = 3;
  localparam int FRAME_W = 2 * NIB_W;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [CNT_W-1:0]   cnt_t;

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking how many frame bits are still to be sent.
// A load takes priority over a decrement; the counter never wraps below zero.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int CNT_W = piso_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] remaining_q;
  logic [CNT_W-1:0] remaining_d;

  // Next count: reload, step down while non-zero, or hold.
  always_comb begin
    remaining_d = remaining_q;
    if (load_i) begin
      remaining_d = load_val_i;
    end else if (dec_i && (remaining_q != '0)) begin
      remaining_d = remaining_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign zero_o = (remaining_q == '0);

endmodule : piso_bit_counter

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register. A load captures {in_hi, in_lo} and
// emits the first bit on q at that same edge; the remaining d bits follow one
// per clock, after which q idles at 0.
// Build option: MSB_FIRST_EN -- when defined, the selected d+1 bits are sent
// from frame[d] down to frame[0]; otherwise they are sent frame[0] upward.
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int NIB_W = piso_pkg::NIB_W,
  parameter int CNT_W = piso_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NIB_W-1:0] in_lo,
  output logic             q,
  input  logic             load,
  input  logic [NIB_W-1:0] in_hi,
  input  logic [CNT_W-1:0] d
);

  localparam int FW = 2 * NIB_W;

  logic [FW-1:0] frame_w;
  logic [FW-1:0] shreg_q;
  logic [FW-1:0] shreg_d;
  logic          q_q;
  logic          q_d;
  logic          cnt_zero;

  assign frame_w = {in_hi, in_lo};

  // Remaining-bit counter: reloaded with d on every load, stepped per sent bit.
  piso_bit_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (d),
    .dec_i      (1'b1),
    .zero_o     (cnt_zero)
  );

`ifdef MSB_FIRST_EN
  // Left-justify frame[d] into the top bit so the shift-left path emits
  // frame[d], frame[d-1], ... frame[0] and ignores bits above d.
  logic [CNT_W-1:0] shamt_w;
  logic [FW-1:0]    aligned_w;

  assign shamt_w   = CNT_W'(FW - 1) - d;
  assign aligned_w = frame_w << shamt_w;

  // Next shift/output state for MSB-first serialisation.
  always_comb begin
    shreg_d = shreg_q;
    q_d     = 1'b0;
    if (load) begin
      q_d     = aligned_w[FW-1];
      shreg_d = {aligned_w[FW-2:0], 1'b0};
    end else if (!cnt_zero) begin
      q_d     = shreg_q[FW-1];
      shreg_d = {shreg_q[FW-2:0], 1'b0};
    end
  end
`else
  // Next shift/output state for LSB-first serialisation.
  always_comb begin
    shreg_d = shreg_q;
    q_d     = 1'b0;
    if (load) begin
      q_d     = frame_w[0];
      shreg_d = {1'b0, frame_w[FW-1:1]};
    end else if (!cnt_zero) begin
      q_d     = shreg_q[0];
      shreg_d = {1'b0, shreg_q[FW-1:1]};
    end
  end
`endif

  // Shift register and registered serial output; reset wins over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      q_q     <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      q_q     <= q_d;
    end
  end

  assign q = q_q;

endmodule : piso_shift_register

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench for piso_shift_register. Stimulus pushes the expected q
// and remaining-count per edge; a negedge monitor pops and compares.
module tb_piso_shift_register;

  logic       clk;
  logic       rst;
  logic [3:0] in_lo;
  logic       q;
  logic       load;
  logic [3:0] in_hi;
  logic [2:0] d;

  typedef struct {
    logic  exp_q;
    int    exp_rem;   // -1: do not check
    string name;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  piso_shift_register dut (
    .clk   (clk),
    .rst   (rst),
    .in_lo (in_lo),
    .q     (q),
    .load  (load),
    .in_hi (in_hi),
    .d     (d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one comparison line per popped transaction.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      int rem_act;
      e = sb.pop_front();
      rem_act = int'(dut.u_cnt.remaining_q);
      n_checks++;
      if (q !== e.exp_q) begin
        n_fail++;
        $display("FAIL %s: q=%0b expected %0b (t=%0t)", e.name, q, e.exp_q, $time);
      end else begin
        $display("ok   %s: q=%0b rem=%0d", e.name, q, rem_act);
      end
      if (e.exp_rem >= 0) begin
        n_checks++;
        if (rem_act != e.exp_rem) begin
          n_fail++;
          $display("FAIL %s_rem: remaining=%0d expected %0d (t=%0t)", e.name, rem_act, e.exp_rem, $time);
        end
      end
    end
  end

  // Drive one edge worth of inputs and queue the expected result.
  task automatic step(input bit r, input bit l, input logic [3:0] hi, input logic [3:0] lo,
                      input logic [2:0] dd, input bit eq, input int erem, input string nm);
    sb_entry_t e;
    rst = r; load = l; in_hi = hi; in_lo = lo; d = dd;
    @(posedge clk);
    #1;
    e.exp_q = eq; e.exp_rem = erem; e.name = nm;
    sb.push_back(e);
  endtask

  // Load a frame, then send its bits with random data on the ignored inputs,
  // then one idle edge. exp_seq[k] is the k-th bit expected on q.
  task automatic frame_tx(input string nm, input logic [7:0] frame, input logic [2:0] dd,
                          input logic [7:0] exp_seq);
    step(0, 1, frame[7:4], frame[3:0], dd, exp_seq[0], int'(dd), $sformatf("%s_b0", nm));
    for (int k = 1; k <= int'(dd); k++) begin
      step(0, 0, 4'($urandom), 4'($urandom), 3'($urandom), exp_seq[k], int'(dd) - k,
           $sformatf("%s_b%0d", nm, k));
    end
    step(0, 0, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 0, $sformatf("%s_idle", nm));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; in_hi = 4'h0; in_lo = 4'hF; d = 3'd0;

    // 1 reset, two edges
    step(1, 0, 4'h0, 4'hF, 3'd0, 1'b0, 0, "reset_e1");
    step(1, 0, 4'h0, 4'hF, 3'd0, 1'b0, 0, "reset_e2");
    step(0, 0, 4'h0, 4'hF, 3'd0, 1'b0, 0, "idle_after_reset");

    // 2 full frame A5: 1,0,1,0,0,1,0,1 in both bit orders
    frame_tx("full_A5", 8'hA5, 3'd7, 8'hA5);

    // 3 short frames
    frame_tx("short_d1", 8'h03, 3'd1, 8'h03);
    frame_tx("short_d0", 8'h01, 3'd0, 8'h01);

    // Bit-order sensitive frames
`ifdef MSB_FIRST_EN
    frame_tx("order_01", 8'h01, 3'd7, 8'h80);  // 0,0,0,0,0,0,0,1
    frame_tx("order_0D", 8'h0D, 3'd3, 8'h0B);  // 1,1,0,1
    frame_tx("order_F6", 8'hF6, 3'd2, 8'h03);  // 1,1,0
`else
    frame_tx("order_01", 8'h01, 3'd7, 8'h01);  // 1,0,0,0,0,0,0,0
    frame_tx("order_0D", 8'h0D, 3'd3, 8'h0D);  // 1,0,1,1
    frame_tx("order_F6", 8'hF6, 3'd2, 8'h06);  // 0,1,1
`endif

    // 4 abort: FF,d=7 for 3 bits, then 00,d=2
    step(0, 1, 4'hF, 4'hF, 3'd7, 1'b1, 7, "abort_b0");
    step(0, 0, 4'h0, 4'h0, 3'd0, 1'b1, 6, "abort_b1");
    step(0, 0, 4'h0, 4'h0, 3'd0, 1'b1, 5, "abort_b2");
    step(0, 1, 4'h0, 4'h0, 3'd2, 1'b0, 2, "abort_new_b0");
    step(0, 0, 4'hF, 4'hF, 3'd7, 1'b0, 1, "abort_new_b1");
    step(0, 0, 4'hF, 4'hF, 3'd7, 1'b0, 0, "abort_new_b2");
    step(0, 0, 4'hF, 4'hF, 3'd7, 1'b0, 0, "abort_idle");

    // 5 load held for 20 edges
    for (int i = 0; i < 10; i++) step(0, 1, 4'h0, 4'b0001, 3'd0, 1'b1, 0, $sformatf("hold_lo1_%0d", i));
    for (int i = 0; i < 10; i++) step(0, 1, 4'h0, 4'b0010, 3'd0, 1'b0, 0, $sformatf("hold_lo2_%0d", i));
    step(0, 0, 4'h0, 4'h0, 3'd0, 1'b0, 0, "hold_release");

    // 6 reset mid-frame during bit 4 of FF
    step(0, 1, 4'hF, 4'hF, 3'd7, 1'b1, 7, "rstmid_b0");
    step(0, 0, 4'h0, 4'h0, 3'd0, 1'b1, 6, "rstmid_b1");
    step(0, 0, 4'h0, 4'h0, 3'd0, 1'b1, 5, "rstmid_b2");
    step(0, 0, 4'h0, 4'h0, 3'd0, 1'b1, 4, "rstmid_b3");
    step(1, 0, 4'h0, 4'h0, 3'd0, 1'b0, 0, "rstmid_rst");
    step(0, 0, 4'h0, 4'h0, 3'd0, 1'b0, 0, "rstmid_idle1");
    step(0, 0, 4'h0, 4'h0, 3'd0, 1'b0, 0, "rstmid_idle2");

    // reset beats load
    step(1, 1, 4'hF, 4'hF, 3'd7, 1'b0, 0, "rst_and_load");
    step(0, 0, 4'hF, 4'hF, 3'd7, 1'b0, 0, "rst_and_load_idle");

    // drain the scoreboard
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_piso_shift_register
